// File: rtl/simd_issue_pkg.sv
// simd_issue_pkg: FSM states, compute-unit opcodes and pipeline-depth helper
// shared by the SIMD issue controller files.
package simd_issue_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] ARITH = 4'd0;
    localparam logic [3:0] CALC  = 4'd1;
    localparam logic [3:0] COMP  = 4'd2;
    localparam logic [3:0] CAST  = 4'd3;

    function automatic int pipe_depth(input int rd_lat, input int cu_lat);
        return rd_lat + cu_lat;
    endfunction

endpackage

// File: rtl/simd_addr_gen.sv
// simd_addr_gen: loadable base plus per-step stride accumulator; the address
// is the low AW bits, so wrap-around is silent.
module simd_addr_gen
    import simd_issue_pkg::*;
#(
    parameter int BW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          adv,
    input  logic [BW-1:0] base,
    input  logic [BW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [BW-1:0] acc;
    logic [BW-1:0] step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc  <= '0;
            step <= '0;
        end else if (load) begin
            acc  <= base;
            step <= stride;
        end else if (adv) begin
            acc <= acc + step;
        end
    end

    assign addr = acc[AW-1:0];

endmodule

// File: rtl/simd_issue_ctrl.sv
// simd_issue_ctrl: sequences one vector instruction into operand reads, compute-unit
// controls and latency-aligned result writes. SIMD_ISSUE_PERF_EN adds perf counters.
module simd_issue_ctrl
    import simd_issue_pkg::*;
#(
    parameter int OPCODE_BITS       = 4,
    parameter int FUNCTION_BITS     = 4,
    parameter int BASE_STRIDE_WIDTH = 32,
    parameter int ADDR_WIDTH        = 10,
    parameter int LOOP_WIDTH        = 16,
    parameter int BUF_RD_LATENCY    = 1,
    parameter int CU_LATENCY        = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [OPCODE_BITS-1:0]       instr_opcode,
    input  logic [FUNCTION_BITS-1:0]     instr_fn,
    input  logic [BASE_STRIDE_WIDTH-1:0] instr_src0_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] instr_src1_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] instr_dst_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] instr_src0_stride,
    input  logic [BASE_STRIDE_WIDTH-1:0] instr_src1_stride,
    input  logic [BASE_STRIDE_WIDTH-1:0] instr_dst_stride,
    input  logic [LOOP_WIDTH-1:0]        instr_iter,
    input  logic                         instr_reduction,
    output logic                         src0_rd_en,
    output logic                         src1_rd_en,
    output logic [ADDR_WIDTH-1:0]        src0_rd_addr,
    output logic [ADDR_WIDTH-1:0]        src1_rd_addr,
    output logic [OPCODE_BITS-1:0]       cu_opcode,
    output logic [FUNCTION_BITS-1:0]     cu_fn,
    output logic                         cu_acc_reset,
    output logic                         cu_reduction_flag,
    output logic                         dst_wr_en,
    output logic [ADDR_WIDTH-1:0]        dst_wr_addr,
    output logic                         busy,
    output logic                         done
`ifdef SIMD_ISSUE_PERF_EN
    ,
    output logic [31:0]                  perf_instr_cnt,
    output logic [31:0]                  perf_busy_cycles
`endif
);

    localparam int D = pipe_depth(BUF_RD_LATENCY, CU_LATENCY);

    state_t                state;
    logic [LOOP_WIDTH-1:0] rem;
    logic                  no_elem;
    logic                  first;
    logic [D-1:0]          tag_v;
    logic [D-1:0]          tag_f;
    logic [D-1:0]          tag_l;
    logic                  accept;
    logic                  rd;
    logic                  wr;

    assign instr_ready  = state == IDLE;
    assign accept       = instr_valid && instr_ready;
    assign rd           = state == ISSUE && rem != '0;
    assign wr           = tag_v[D-1] && (!cu_reduction_flag || tag_l[D-1]);
    assign src0_rd_en   = rd;
    assign src1_rd_en   = rd;
    assign dst_wr_en    = wr;
    assign busy         = state == ISSUE || state == DRAIN;
    assign done         = state == DONE;
    // Accumulator is cleared while idle, for empty instructions, and as element 0 enters the CU.
    assign cu_acc_reset = !busy || no_elem || tag_f[BUF_RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            rem               <= '0;
            no_elem           <= 1'b0;
            first             <= 1'b0;
            tag_v             <= '0;
            tag_f             <= '0;
            tag_l             <= '0;
            cu_opcode         <= '0;
            cu_fn             <= '0;
            cu_reduction_flag <= 1'b0;
        end else begin
            tag_v <= {tag_v[D-2:0], rd};
            tag_f <= {tag_f[D-2:0], rd && first};
            tag_l <= {tag_l[D-2:0], rd && rem == LOOP_WIDTH'(1)};
            if (rd) begin
                rem   <= rem - LOOP_WIDTH'(1);
                first <= 1'b0;
            end
            case (state)
                IDLE: if (accept) begin
                    state             <= ISSUE;
                    rem               <= instr_iter;
                    no_elem           <= instr_iter == '0;
                    first             <= 1'b1;
                    cu_opcode         <= instr_opcode;
                    cu_fn             <= instr_fn;
                    cu_reduction_flag <= instr_reduction;
                end
                ISSUE: begin
                    if (rem == '0) state <= DONE;
                    else if (rem == LOOP_WIDTH'(1)) state <= DRAIN;
                end
                // The last element is on its write cycle once no earlier stage holds a tag.
                DRAIN: if (tag_v[D-2:0] == '0) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    simd_addr_gen #(.BW(BASE_STRIDE_WIDTH), .AW(ADDR_WIDTH)) u_src0 (
        .clk(clk), .reset(reset), .load(accept), .adv(rd),
        .base(instr_src0_base), .stride(instr_src0_stride), .addr(src0_rd_addr)
    );

    simd_addr_gen #(.BW(BASE_STRIDE_WIDTH), .AW(ADDR_WIDTH)) u_src1 (
        .clk(clk), .reset(reset), .load(accept), .adv(rd),
        .base(instr_src1_base), .stride(instr_src1_stride), .addr(src1_rd_addr)
    );

    simd_addr_gen #(.BW(BASE_STRIDE_WIDTH), .AW(ADDR_WIDTH)) u_dst (
        .clk(clk), .reset(reset), .load(accept), .adv(wr && !cu_reduction_flag),
        .base(instr_dst_base), .stride(instr_dst_stride), .addr(dst_wr_addr)
    );

`ifdef SIMD_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_instr_cnt   <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (accept && !(&perf_instr_cnt)) perf_instr_cnt <= perf_instr_cnt + 32'd1;
            if (busy && !(&perf_busy_cycles)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// tb_simd_issue_ctrl: directed vector table plus back-to-back and mid-instruction
// reset sequences for simd_issue_ctrl at default parameters.
module tb_simd_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [3:0]  instr_fn;
    logic [31:0] instr_src0_base, instr_src1_base, instr_dst_base;
    logic [31:0] instr_src0_stride, instr_src1_stride, instr_dst_stride;
    logic [15:0] instr_iter;
    logic        instr_reduction;
    logic        src0_rd_en, src1_rd_en;
    logic [9:0]  src0_rd_addr, src1_rd_addr;
    logic [3:0]  cu_opcode;
    logic [3:0]  cu_fn;
    logic        cu_acc_reset;
    logic        cu_reduction_flag;
    logic        dst_wr_en;
    logic [9:0]  dst_wr_addr;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    simd_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_fn(instr_fn),
        .instr_src0_base(instr_src0_base), .instr_src1_base(instr_src1_base),
        .instr_dst_base(instr_dst_base), .instr_src0_stride(instr_src0_stride),
        .instr_src1_stride(instr_src1_stride), .instr_dst_stride(instr_dst_stride),
        .instr_iter(instr_iter), .instr_reduction(instr_reduction),
        .src0_rd_en(src0_rd_en), .src1_rd_en(src1_rd_en),
        .src0_rd_addr(src0_rd_addr), .src1_rd_addr(src1_rd_addr),
        .cu_opcode(cu_opcode), .cu_fn(cu_fn), .cu_acc_reset(cu_acc_reset),
        .cu_reduction_flag(cu_reduction_flag), .dst_wr_en(dst_wr_en),
        .dst_wr_addr(dst_wr_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        logic [3:0]      fn;
        logic            red;
        logic [15:0]     iter;
        logic [31:0]     s0b, s0s, s1b, s1s, db, ds;
        int              n_rd, n_wr, first_wr, last_wr;
        logic [3:0][9:0] s0a;
        logic [9:0]      s1l, wf, wl;
        int              done_cyc, acc_cnt, acc_first;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_opcode      = v.op;
        instr_fn          = v.fn;
        instr_reduction   = v.red;
        instr_iter        = v.iter;
        instr_src0_base   = v.s0b;
        instr_src0_stride = v.s0s;
        instr_src1_base   = v.s1b;
        instr_src1_stride = v.s1s;
        instr_dst_base    = v.db;
        instr_dst_stride  = v.ds;
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_ready"}, instr_ready, 1);
        chk({p, "_acc_reset"}, cu_acc_reset, 1);
        chk({p, "_rd_en"}, {src0_rd_en, src1_rd_en}, 0);
        chk({p, "_wr_en"}, dst_wr_en, 0);
        chk({p, "_cu_ctl"}, {cu_opcode, cu_fn, cu_reduction_flag}, 0);
        chk({p, "_addrs"}, {src0_rd_addr, src1_rd_addr, dst_wr_addr}, 0);
        chk({p, "_busy_done"}, {busy, done}, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n_rd = 0, n_wr = 0, first_wr = -1, last_wr = -1, done_cyc = -1;
        int acc_cnt = 0, acc_first = -1, bad = 0;
        logic [3:0][9:0] s0a = '0;
        logic [9:0] s1l = '0, wf = '0, wl = '0;
        string p = $sformatf("vec%0d", idx);
        chk({p, "_ready_before"}, instr_ready, 1);
        drive(v);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int c = 0; c < 20 && done_cyc < 0; c++) begin
            if (src0_rd_en) begin
                if (n_rd < 4) s0a[n_rd] = src0_rd_addr;
                s1l = src1_rd_addr;
                n_rd++;
            end
            if (src0_rd_en !== src1_rd_en) bad++;
            if (dst_wr_en) begin
                if (n_wr == 0) begin
                    first_wr = c;
                    wf = dst_wr_addr;
                end
                last_wr = c;
                wl = dst_wr_addr;
                n_wr++;
            end
            if (cu_opcode !== v.op || cu_fn !== v.fn || cu_reduction_flag !== v.red) bad++;
            if (done) done_cyc = c;
            else if (cu_acc_reset) begin
                if (acc_first < 0) acc_first = c;
                acc_cnt++;
            end
            tick();
        end
        chk({p, "_n_rd"}, n_rd, v.n_rd);
        chk({p, "_n_wr"}, n_wr, v.n_wr);
        chk({p, "_first_wr_cyc"}, first_wr, v.first_wr);
        chk({p, "_last_wr_cyc"}, last_wr, v.last_wr);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_src0_addr%0d", p, i), s0a[i], v.s0a[i]);
        chk({p, "_src1_last_addr"}, s1l, v.s1l);
        chk({p, "_dst_first_addr"}, wf, v.wf);
        chk({p, "_dst_last_addr"}, wl, v.wl);
        chk({p, "_done_cyc"}, done_cyc, v.done_cyc);
        chk({p, "_acc_reset_cnt"}, acc_cnt, v.acc_cnt);
        chk({p, "_acc_reset_first"}, acc_first, v.acc_first);
        chk({p, "_ctl_stable"}, bad, 0);
        chk({p, "_ready_after_done"}, instr_ready, 1);
        chk({p, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int bad, early, last_wr, seen, wr_cnt, rd_cnt, done_cnt;
        vecs[0] = '{4'h0, 4'h0, 1'b0, 16'd4, 32'h10, 32'd1, 32'h20, 32'd2, 32'h30, 32'd1,
                    4, 4, 2, 5, {10'h013, 10'h012, 10'h011, 10'h010}, 10'h026, 10'h030, 10'h033, 6, 1, 1};
        vecs[1] = '{4'h1, 4'h2, 1'b1, 16'd3, 32'h0, 32'd1, 32'h100, 32'd4, 32'h40, 32'd5,
                    3, 1, 4, 4, {10'h000, 10'h002, 10'h001, 10'h000}, 10'h108, 10'h040, 10'h040, 5, 1, 1};
        vecs[2] = '{4'h3, 4'h1, 1'b0, 16'd0, 32'h55, 32'd3, 32'h66, 32'd3, 32'h77, 32'd3,
                    0, 0, -1, -1, {10'h000, 10'h000, 10'h000, 10'h000}, 10'h000, 10'h000, 10'h000, 1, 1, 0};
        vecs[3] = '{4'h2, 4'h5, 1'b0, 16'd4, 32'h3FE, 32'd1, 32'h5, 32'hFFFF_FFFF, 32'h3FF, 32'd2,
                    4, 4, 2, 5, {10'h001, 10'h000, 10'h3FF, 10'h3FE}, 10'h002, 10'h3FF, 10'h005, 6, 1, 1};
        vecs[4] = '{4'hF, 4'hA, 1'b0, 16'd2, 32'h12345, 32'h400, 32'h0, 32'h10, 32'h0, 32'h401,
                    2, 2, 2, 3, {10'h000, 10'h000, 10'h345, 10'h345}, 10'h010, 10'h000, 10'h001, 4, 1, 1};
        reset = 1'b0;
        instr_valid = 1'b0;
        drive(vecs[0]);
        repeat (3) tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Back-to-back: valid stays high with a second instruction queued behind the first.
        drive(vecs[0]);
        instr_valid = 1'b1;
        tick();
        instr_opcode = 4'h2;
        bad = 0;
        early = 0;
        last_wr = -1;
        for (int c = 0; c < 7; c++) begin
            if (cu_opcode !== 4'h0) bad++;
            if (instr_ready) early++;
            if (dst_wr_en) last_wr = c;
            tick();
        end
        chk("b2b_opcode_held", bad, 0);
        chk("b2b_no_early_ready", early, 0);
        chk("b2b_last_wr_cyc", last_wr, 5);
        chk("b2b_ready_c7", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        chk("b2b_second_opcode", cu_opcode, 4'h2);
        chk("b2b_second_busy", busy, 1);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (done) seen = 1;
            tick();
        end
        chk("b2b_second_done", seen, 1);

        // Reset lands in cycle 2 of a running instruction.
        drive(vecs[0]);
        instr_opcode = 4'h1;
        instr_fn = 4'h3;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_idle("midreset");
        reset = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (dst_wr_en) wr_cnt++;
            if (src0_rd_en) rd_cnt++;
            if (done) done_cnt++;
            tick();
        end
        chk("midreset_no_wr", wr_cnt, 0);
        chk("midreset_no_rd", rd_cnt, 0);
        chk("midreset_no_done", done_cnt, 0);
        chk("midreset_ready", instr_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
